// File: rtl/id_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// id_stage_pipe_if
//   Handshake and payload bundle for the registered ID stage.
//   IF side : in_valid / in_ready, instruction, pc_plus4
//   EX side : out_valid / out_ready, decoded fields, imm_ext, jump_addr,
//             pc_out and the class flags.
//   modport slave  : the ID stage itself (consumes IF, produces for EX)
//   modport master : the surrounding pipeline / testbench
//   PC_W and IMM_W must match the parameters of the id_stage_pipe instance.
// ---------------------------------------------------------------------------
interface id_stage_pipe_if #(
  parameter int PC_W  = 32,
  parameter int IMM_W = 32
);
  // IF -> ID
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic [PC_W-1:0]  pc_plus4;
  // ID -> EX
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       opcode;
  logic [5:0]       func;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [IMM_W-1:0] imm_ext;
  logic [PC_W-1:0]  jump_addr;
  logic [PC_W-1:0]  pc_out;
  logic             is_r;
  logic             is_j;
  logic             is_load;
  logic             is_store;
  logic             is_branch;

  modport slave (
    input  in_valid, instruction, pc_plus4, out_ready,
    output in_ready, out_valid, opcode, func, rs, rt, rd, shamt,
           imm_ext, jump_addr, pc_out, is_r, is_j, is_load, is_store, is_branch
  );

  modport master (
    output in_valid, instruction, pc_plus4, out_ready,
    input  in_ready, out_valid, opcode, func, rs, rt, rd, shamt,
           imm_ext, jump_addr, pc_out, is_r, is_j, is_load, is_store, is_branch
  );
endinterface

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
//   Registered MIPS instruction-decode stage. Accepts {instruction, pc_plus4}
//   from IF over valid/ready, splits the fields, extends the immediate, forms
//   the jump target and class flags, and holds one decoded bundle for EX.
//   Load-use hazards against the instruction in EX stall the input side.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     bus          id_stage_pipe_if.slave (IF and EX handshakes + payload)
//     flush        squash held and incoming instruction (taken branch)
//     ex_mem_read  instruction in EX is a load
//     ex_rt        destination register of that load
//     stall_count  saturating count of cycles stalled on a load-use hazard
// ---------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int PC_W      = 32,  // 28..64
  parameter int IMM_W     = 32,  // 32..64
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_stage_pipe_if.slave   bus,
  input  logic             flush,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  output logic [CNT_W-1:0] stall_count
);

  // Field split of the incoming instruction
  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs_f;
  logic [4:0]  rt_f;
  logic [15:0] imm16;

  assign op    = bus.instruction[31:26];
  assign fn    = bus.instruction[5:0];
  assign rs_f  = bus.instruction[25:21];
  assign rt_f  = bus.instruction[20:16];
  assign imm16 = bus.instruction[15:0];

  // Load-use hazard: only register fields the instruction actually reads
  // count. Jumps and lui read no rs; shifts-by-immediate read no rs.
  logic uses_rs;
  logic uses_rt;
  logic hazard;
  logic in_ready_i;
  logic accept;

  always_comb begin
    uses_rs = !(op inside {6'h02, 6'h03, 6'h0F}) &&
              !(op == 6'h00 && (fn inside {6'h00, 6'h02, 6'h03}));
    uses_rt = op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
    hazard  = (HAZARD_EN != 0) && ex_mem_read && (ex_rt != 5'd0) &&
              ((uses_rs && rs_f == ex_rt) || (uses_rt && rt_f == ex_rt));
  end

  // Ready is independent of in_valid so IF may wait on it without a loop.
  assign in_ready_i   = !flush && !hazard && (!bus.out_valid || bus.out_ready);
  assign bus.in_ready = in_ready_i;
  assign accept       = bus.in_valid && in_ready_i;

  // Immediate extension: logical ops zero-extend, lui places imm16 in the
  // upper half of a 32-bit word and sign-extends that word, the rest
  // sign-extend imm16.
  logic [IMM_W-1:0] imm_d;

  always_comb begin
    // NOTE: default assignment first so every path drives imm_d; without it
    // a missed branch would infer a latch.
    imm_d = IMM_W'($signed(imm16));
    if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
      imm_d = IMM_W'(imm16);
    end else if (op == 6'h0F) begin
      imm_d = IMM_W'($signed({imm16, 16'h0000}));
    end
  end

  // Jump target keeps the PC region bits above 28; none exist at PC_W==28.
  logic [PC_W-1:0] jump_d;

  if (PC_W == 28) begin : g_jump_narrow
    assign jump_d = {bus.instruction[25:0], 2'b00};
  end else begin : g_jump_wide
    assign jump_d = {bus.pc_plus4[PC_W-1:28], bus.instruction[25:0], 2'b00};
  end

  // Output register. Priority: flush > accept > drain > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the held bundle is a handful of flops, not a memory, so it is
      // cleared on reset to give EX a defined, all-zero view.
      bus.out_valid <= 1'b0;
      bus.opcode    <= '0;
      bus.func      <= '0;
      bus.rs        <= '0;
      bus.rt        <= '0;
      bus.rd        <= '0;
      bus.shamt     <= '0;
      bus.imm_ext   <= '0;
      bus.jump_addr <= '0;
      bus.pc_out    <= '0;
      bus.is_r      <= 1'b0;
      bus.is_j      <= 1'b0;
      bus.is_load   <= 1'b0;
      bus.is_store  <= 1'b0;
      bus.is_branch <= 1'b0;
      stall_count   <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // values from before this edge, independent of statement order.
      if (bus.in_valid && hazard && !flush && stall_count != '1) begin
        stall_count <= stall_count + CNT_W'(1);
      end

      if (flush) begin
        bus.out_valid <= 1'b0;
      end else if (accept) begin
        bus.out_valid <= 1'b1;
        bus.opcode    <= op;
        bus.func      <= fn;
        bus.rs        <= rs_f;
        bus.rt        <= rt_f;
        bus.rd        <= bus.instruction[15:11];
        bus.shamt     <= bus.instruction[10:6];
        bus.imm_ext   <= imm_d;
        bus.jump_addr <= jump_d;
        bus.pc_out    <= bus.pc_plus4;
        bus.is_r      <= (op == 6'h00);
        bus.is_j      <= op inside {6'h02, 6'h03};
        bus.is_load   <= op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        bus.is_store  <= op inside {6'h28, 6'h29, 6'h2B};
        bus.is_branch <= op inside {[6'h04:6'h07]};
      end else if (bus.out_ready) begin
        // Drain: also the path taken while a hazard holds off the input.
        bus.out_valid <= 1'b0;
      end
      // Otherwise hold: out_valid && !out_ready, bundle stays bit-stable.
    end
  end

endmodule
